ixc_drv_arb: RTL and testbench

//  Arbitrates N emulated tri-state drivers that share one resolved net.

---
 rtl/ixc_drv_pkg.sv | 19 +
 rtl/ixc_rr_pick.sv | 36 +++
 rtl/ixc_drv_arb.sv | 140 ++++++++++++++
 tb/tb_ixc_drv_arb.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ixc_drv_pkg.sv
// Shared types for the emulated tri-state driver arbiter.
// Arbiter states plus a small index helper.
package ixc_drv_pkg;

    localparam int ST_W    = 2;
    localparam int MAX_DRV = 16;

    typedef enum logic [ST_W-1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } drvState_t;

    // Next driver index after i, wrapping at n.
    function automatic int wrapInc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/ixc_rr_pick.sv
// Round-robin picker: first set req at or above ptr, wrapping; purely combinational.
// Zero latency, no state; the caller decides when a pick is taken.
module ixc_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  oneHot,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int cand;
        logic [IW-1:0] candIdx;
        oneHot  = '0;
        idx     = '0;
        any     = 1'b0;
        cand    = 0;
        candIdx = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            candIdx = IW'(cand);
            if (!any && req[candIdx]) begin
                any             = 1'b1;
                idx             = candIdx;
                oneHot[candIdx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ixc_drv_arb.sv
// Round-robin owner of one emulated tri-state net with a one-cycle turnaround between owners.
// Latency: en sampled -> grant/bus_oe after the next edge; an owner is never preempted.
// IXC_DRV_PULL_EN: drive PULL_VAL whenever the net is undriven instead of keeping the last value.
module ixc_drv_arb
    import ixc_drv_pkg::*;
#(
    parameter int            N_DRV    = 4,
    parameter int            DW       = 8,
    parameter int            CNT_W    = 16,
    parameter logic [DW-1:0] PULL_VAL = '0
) (
    input  logic                     fclk,
    input  logic                     rst,
    input  logic [N_DRV-1:0]         en,
    input  logic [N_DRV*DW-1:0]      din,
    output logic [N_DRV-1:0]         grant,
    output logic [$clog2(N_DRV)-1:0] owner_idx,
    output logic [DW-1:0]            bus_out,
    output logic                     bus_oe,
    output logic [N_DRV-1:0]         drv_on,
    output logic                     contention,
    output logic [CNT_W-1:0]         cont_cnt
);

    localparam int IW = $clog2(N_DRV);

    drvState_t        state;
    drvState_t        stateNxt;
    logic [N_DRV-1:0] enQ;
    logic [N_DRV-1:0] grantQ;
    logic [N_DRV-1:0] pickOneHot;
    logic [IW-1:0]    ownerQ;
    logic [IW-1:0]    rrPtr;
    logic [IW-1:0]    pickIdx;
    logic             pickAny;
    logic             ownerEn;
    logic             takeGrant;
    logic             multiEn;
    logic             contQ;
    logic [CNT_W-1:0] contCnt;
    logic [DW-1:0]    ownerDat;
    logic [DW-1:0]    idleVal;

    ixc_rr_pick #(
        .N  (N_DRV),
        .IW (IW)
    ) uPick (
        .req    (en),
        .ptr    (rrPtr),
        .oneHot (pickOneHot),
        .idx    (pickIdx),
        .any    (pickAny)
    );

    assign drv_on    = en ^ enQ;
    assign ownerEn   = |(en & grantQ);
    assign multiEn   = ($countones(en) > 1);
    // A new owner is only taken from IDLE or TURN, which is what forces the turnaround.
    assign takeGrant = (state != OWN) && pickAny;

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE, TURN: stateNxt = pickAny ? OWN : IDLE;
            OWN:        stateNxt = ownerEn ? OWN : TURN;
            default:    stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            enQ     <= '0;
            grantQ  <= '0;
            ownerQ  <= '0;
            rrPtr   <= '0;
            contQ   <= 1'b0;
            contCnt <= '0;
        end else begin
            enQ   <= en;
            contQ <= multiEn;
            if (multiEn && (contCnt != '1)) begin
                contCnt <= contCnt + 1'b1;
            end
            if (takeGrant) begin
                grantQ <= pickOneHot;
                ownerQ <= pickIdx;
                rrPtr  <= IW'(wrapInc(int'(pickIdx), N_DRV));
            end else if ((state == OWN) && !ownerEn) begin
                grantQ <= '0;
            end
        end
    end

    always_comb begin
        ownerDat = '0;
        for (int i = 0; i < N_DRV; i++) begin
            if (ownerQ == IW'(i)) begin
                ownerDat = din[i*DW +: DW];
            end
        end
    end

`ifdef IXC_DRV_PULL_EN
    assign idleVal = PULL_VAL;
`else
    logic [DW-1:0] keepQ;
    logic          unusedPull;

    // Keeper tracks what the owner drove on its final cycle so the net holds it.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            keepQ <= '0;
        end else if (state == OWN) begin
            keepQ <= ownerDat;
        end
    end

    assign idleVal    = keepQ;
    assign unusedPull = ^PULL_VAL;
`endif

    always_comb begin
        bus_oe  = (state == OWN);
        bus_out = (state == OWN) ? ownerDat : idleVal;
    end

    assign grant      = grantQ;
    assign owner_idx  = ownerQ;
    assign contention = contQ;
    assign cont_cnt   = contCnt;

endmodule

// File: tb/tb_ixc_drv_arb.sv
// Bench for ixc_drv_arb: directed scenarios plus random enables against a behavioural model.
// Honours IXC_DRV_PULL_EN for the idle net value.
module tb_ixc_drv_arb;

    localparam int            N    = 4;
    localparam int            DW   = 8;
    localparam int            CW   = 4;
    localparam logic [DW-1:0] PULL = 8'hFF;
`ifdef IXC_DRV_PULL_EN
    localparam logic [DW-1:0] IDLE_RST = PULL;
    localparam logic [DW-1:0] EXP_T6   = PULL;
`else
    localparam logic [DW-1:0] IDLE_RST = 8'h00;
    localparam logic [DW-1:0] EXP_T6   = 8'h3C;
`endif

    logic            fclk = 1'b0;
    logic            rst;
    logic [N-1:0]    en;
    logic [N*DW-1:0] din;
    logic [N-1:0]    grant;
    logic [1:0]      owner_idx;
    logic [DW-1:0]   bus_out;
    logic            bus_oe;
    logic [N-1:0]    drv_on;
    logic            contention;
    logic [CW-1:0]   cont_cnt;

    ixc_drv_arb #(
        .N_DRV    (N),
        .DW       (DW),
        .CNT_W    (CW),
        .PULL_VAL (PULL)
    ) dut (
        .fclk       (fclk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .grant      (grant),
        .owner_idx  (owner_idx),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .drv_on     (drv_on),
        .contention (contention),
        .cont_cnt   (cont_cnt)
    );

    always #5 fclk = ~fclk;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the net, where the next search starts, what the net last carried.
    bit            mOwn;
    int            mOwner;
    int            mPtr;
    logic [DW-1:0] mKeep;
    bit            mCont;
    int            mCnt;
    logic [N-1:0]  mEnQ;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] putByte(input logic [N*DW-1:0] base, input int i,
                                                input logic [DW-1:0] b);
        logic [N*DW-1:0] r;
        r = base;
        r[i*DW +: DW] = b;
        return r;
    endfunction

    task automatic mdlReset();
        mOwn   = 1'b0;
        mOwner = 0;
        mPtr   = 0;
        mKeep  = '0;
        mCont  = 1'b0;
        mCnt   = 0;
        mEnQ   = '0;
    endtask

    task automatic mdlEdge();
        int pc = $countones(en);
        mCont = (pc > 1);
        if (pc > 1 && mCnt < (1 << CW) - 1) mCnt++;
        if (mOwn) begin
            mKeep = din[mOwner*DW +: DW];
            if (!en[mOwner]) mOwn = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c = (mPtr + k) % N;
                if (en[c]) begin
                    mOwn   = 1'b1;
                    mOwner = c;
                    mPtr   = (c + 1) % N;
                    break;
                end
            end
        end
        mEnQ = en;
    endtask

    task automatic checkModel(input string tag);
        logic [DW-1:0] idleV;
`ifdef IXC_DRV_PULL_EN
        idleV = PULL;
`else
        idleV = mKeep;
`endif
        chk({tag, ".grant"}, grant, mOwn ? (32'd1 << mOwner) : 32'd0);
        chk({tag, ".oe"}, bus_oe, mOwn);
        if (mOwn) chk({tag, ".owner"}, owner_idx, mOwner);
        chk({tag, ".bus"}, bus_out, mOwn ? din[mOwner*DW +: DW] : idleV);
        chk({tag, ".drvOn"}, drv_on, en ^ mEnQ);
        chk({tag, ".cont"}, contention, mCont);
        chk({tag, ".cnt"}, cont_cnt, mCnt);
    endtask

    task automatic apply(input logic [N-1:0] e, input logic [N*DW-1:0] d, input string tag);
        en  = e;
        din = d;
        #1;
        checkModel(tag);
    endtask

    task automatic tick(input string tag);
        @(posedge fclk);
        mdlEdge();
        @(negedge fclk);
        #1;
        checkModel(tag);
    endtask

    task automatic doReset();
        rst = 1'b1;
        en  = '0;
        din = '0;
        mdlReset();
        @(negedge fclk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int           expOrder[5];
        logic [N-1:0] e;
        logic [N-1:0] dropEn;
        logic [N*DW-1:0] d;

        rst = 1'b0;
        en  = '0;
        din = '0;
        mdlReset();
        #1 rst = 1'b1;
        #1;
        chk("rst.grant", grant, 0);
        chk("rst.owner", owner_idx, 0);
        chk("rst.oe", bus_oe, 0);
        chk("rst.bus", bus_out, IDLE_RST);
        chk("rst.cont", contention, 0);
        chk("rst.cnt", cont_cnt, 0);
        en = 4'b0101;
        #1;
        chk("rst.drvOn", drv_on, 4'b0101);
        en = '0;
        @(negedge fclk);
        rst = 1'b0;
        #1;

        // Single driver: one-edge grant latency, data passes through, enable toggle pulses.
        doReset();
        d = putByte('0, 2, 8'hA5);
        apply(4'b0100, d, "t1.rise");
        chk("t1.pulse", drv_on, 4'b0100);
        tick("t1.own");
        chk("t1.grant", grant, 4'b0100);
        chk("t1.oe", bus_oe, 1);
        chk("t1.bus", bus_out, 8'hA5);
        chk("t1.noPulse", drv_on, 4'b0000);
        apply(4'b0000, d, "t1.fall");
        chk("t1.fallPulse", drv_on, 4'b0100);
        tick("t1.turn");
        tick("t1.idle");

        // Two contenders: lower index wins from reset pointer, turnaround on handover.
        doReset();
        d = putByte(putByte('0, 0, 8'h11), 1, 8'h22);
        apply(4'b0011, d, "t2.req");
        tick("t2.own0");
        chk("t2.grant0", grant, 4'b0001);
        chk("t2.cont", contention, 1);
        chk("t2.cnt1", cont_cnt, 1);
        tick("t2.hold");
        chk("t2.cnt2", cont_cnt, 2);
        apply(4'b0010, d, "t2.drop");
        tick("t2.turn");
        chk("t2.turnOe", bus_oe, 0);
        chk("t2.cnt2b", cont_cnt, 2);
        tick("t2.own1");
        chk("t2.grant1", grant, 4'b0010);
        chk("t2.bus1", bus_out, 8'h22);

        // Round-robin order with all drivers requesting.
        doReset();
        expOrder = '{0, 1, 2, 3, 0};
        d = 32'h44332211;
        for (int h = 0; h < 5; h++) begin
            apply(4'b1111, d, "t3.all");
            tick("t3.own");
            chk("t3.owner", owner_idx, expOrder[h]);
            chk("t3.oe", bus_oe, 1);
            tick("t3.hold");
            dropEn = 4'b1111;
            dropEn[expOrder[h]] = 1'b0;
            apply(dropEn, d, "t3.drop");
            tick("t3.turn");
            chk("t3.turnOe", bus_oe, 0);
        end

        // Contention counter saturates without wrapping.
        doReset();
        apply(4'b1111, 32'hDEADBEEF, "t4.all");
        for (int c = 0; c < 20; c++) tick("t4.hold");
        chk("t4.sat", cont_cnt, 4'hF);
        chk("t4.cont", contention, 1);

        // Asynchronous reset while owning, then regrant after release.
        doReset();
        d = putByte('0, 2, 8'h5A);
        apply(4'b0100, d, "t5.req");
        tick("t5.own");
        chk("t5.oe", bus_oe, 1);
        rst = 1'b1;
        #1;
        chk("t5.rstGrant", grant, 0);
        chk("t5.rstOe", bus_oe, 0);
        mdlReset();
        checkModel("t5.inRst");
        @(negedge fclk);
        rst = 1'b0;
        #1;
        tick("t5.regrant");
        chk("t5.grant", grant, 4'b0100);
        chk("t5.bus", bus_out, 8'h5A);

        // Idle net value after the owner leaves: keeper or pull.
        doReset();
        d = putByte('0, 0, 8'h3C);
        apply(4'b0001, d, "t6.req");
        tick("t6.own");
        chk("t6.bus", bus_out, 8'h3C);
        apply(4'b0000, d, "t6.drop");
        tick("t6.turn");
        apply(4'b0000, '0, "t6.clr");
        tick("t6.idle");
        chk("t6.idleBus", bus_out, EXP_T6);

        // Random enables with occasional asynchronous resets.
        doReset();
        e = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) e = N'($urandom);
            apply(e, $urandom, "rnd.in");
            tick("rnd.edge");
            if ($urandom_range(0, 63) == 0) begin
                rst = 1'b1;
                #1;
                mdlReset();
                checkModel("rnd.rst");
                @(negedge fclk);
                rst = 1'b0;
                #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
